// File: rtl/pipeline_hazard_controller.sv
// rtl/pipeline_hazard_controller.sv - pipeline stall/flush/memory-wait sequencing controller
module pipeline_hazard_controller #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             err_clear,
  input  logic             stat_clear,
  output logic             pc_enable,
  output logic             if_id_enable,
  output logic             id_ex_enable,
  output logic             ex_mem_enable,
  output logic             mem_wb_enable,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic             mem_timeout
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    FLUSH    = 2'b01,
    MEM_WAIT = 2'b10
  } state_t;

  localparam logic [1:0]  FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);
  localparam logic [15:0] TIMEOUT      = 16'(MEM_TIMEOUT);

  state_t      cur, nxt;
  logic [1:0]  flush_cnt, flush_nxt;
  logic [15:0] wait_cnt, wait_nxt;
  logic        mem_hold, load_use, wait_expired, mem_done, set_timeout;
  logic        pc_en, if_id_en, back_en, if_id_fl, id_ex_fl;

  assign mem_hold     = dmem_req & ~dmem_ready;
  assign load_use     = ex_mem_read & (ex_rd != 5'd0) &
                        ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
  assign wait_expired = (wait_cnt == TIMEOUT);
  // A dropped request is treated the same as a completed one.
  assign mem_done     = ~mem_hold | wait_expired;
  assign set_timeout  = (cur == MEM_WAIT) & mem_hold & wait_expired;

  always_comb begin
    pc_en     = 1'b1;
    if_id_en  = 1'b1;
    back_en   = 1'b1;
    if_id_fl  = 1'b0;
    id_ex_fl  = 1'b0;
    nxt       = cur;
    flush_nxt = flush_cnt;
    wait_nxt  = wait_cnt;
    if (cur == MEM_WAIT && !mem_done) begin
      pc_en    = 1'b0;
      if_id_en = 1'b0;
      back_en  = 1'b0;
      wait_nxt = wait_cnt + 16'd1;
    end else if (cur != MEM_WAIT && mem_hold) begin
      pc_en    = 1'b0;
      if_id_en = 1'b0;
      back_en  = 1'b0;
      nxt      = MEM_WAIT;
      wait_nxt = 16'd1;
    end else if (cur == FLUSH) begin
      if_id_fl = 1'b1;
      if (ex_branch_taken) begin
        id_ex_fl  = 1'b1;
        flush_nxt = FLUSH_RELOAD;
        nxt       = (FLUSH_RELOAD != 2'd0) ? FLUSH : RUN;
      end else begin
        flush_nxt = flush_cnt - 2'd1;
        nxt       = (flush_cnt <= 2'd1) ? RUN : FLUSH;
      end
    end else begin
      // RUN, or the cycle a memory wait completes: ordinary hazard rules apply.
      if (cur == MEM_WAIT)
        nxt = (flush_cnt != 2'd0) ? FLUSH : RUN;
      if (ex_branch_taken) begin
        if_id_fl  = 1'b1;
        id_ex_fl  = 1'b1;
        flush_nxt = FLUSH_RELOAD;
        nxt       = (FLUSH_RELOAD != 2'd0) ? FLUSH : RUN;
      end else if (load_use) begin
        pc_en    = 1'b0;
        if_id_en = 1'b0;
        id_ex_fl = 1'b1;
      end
    end
  end

  // In reset the outputs look like an idle RUN cycle regardless of inputs.
  assign pc_enable     = ~reset | pc_en;
  assign if_id_enable  = ~reset | if_id_en;
  assign id_ex_enable  = ~reset | back_en;
  assign ex_mem_enable = ~reset | back_en;
  assign mem_wb_enable = ~reset | back_en;
  assign if_id_flush   = reset & if_id_fl;
  assign id_ex_flush   = reset & id_ex_fl;
  assign state         = cur;

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      cur         <= RUN;
      flush_cnt   <= 2'd0;
      wait_cnt    <= 16'd0;
      stall_count <= '0;
      mem_timeout <= 1'b0;
    end else begin
      cur       <= nxt;
      flush_cnt <= flush_nxt;
      wait_cnt  <= wait_nxt;
      if (stat_clear)
        stall_count <= '0;
      else if (!pc_en && stall_count != '1)
        stall_count <= stall_count + 1'b1;
      if (set_timeout)
        mem_timeout <= 1'b1;
      else if (err_clear)
        mem_timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb/tb_pipeline_hazard_controller.sv - directed scoreboard bench for pipeline_hazard_controller
module tb_pipeline_hazard_controller;

  logic       clk = 1'b1;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
  logic       dmem_req, dmem_ready, err_clear, stat_clear;
  logic       pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable;
  logic       if_id_flush, id_ex_flush, mem_timeout;
  logic [1:0] state;
  logic [3:0] stall_count;

  pipeline_hazard_controller #(.FLUSH_CYCLES(3), .MEM_TIMEOUT(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .dmem_req(dmem_req),
    .dmem_ready(dmem_ready), .err_clear(err_clear), .stat_clear(stat_clear),
    .pc_enable(pc_enable), .if_id_enable(if_id_enable), .id_ex_enable(id_ex_enable),
    .ex_mem_enable(ex_mem_enable), .mem_wb_enable(mem_wb_enable),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .state(state),
    .stall_count(stall_count), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush, state}
  localparam logic [8:0] NORM0 = 9'b11111_00_00;
  localparam logic [8:0] NORM2 = 9'b11111_00_10;
  localparam logic [8:0] LU0   = 9'b00111_01_00;
  localparam logic [8:0] BR0   = 9'b11111_11_00;
  localparam logic [8:0] FL1   = 9'b11111_10_01;
  localparam logic [8:0] FLBR1 = 9'b11111_11_01;
  localparam logic [8:0] HOLD0 = 9'b00000_00_00;
  localparam logic [8:0] HOLD1 = 9'b00000_00_01;
  localparam logic [8:0] HOLD2 = 9'b00000_00_10;

  int         total = 0;
  int         bad = 0;
  int         exp_stall = 0;
  logic       exp_to = 1'b0;
  logic [8:0] sb_q[$];
  logic [8:0] obs;

  assign obs = {pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable,
                if_id_flush, id_ex_flush, state};

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic [8:0] exp);
    logic [8:0] e;
    sb_q.push_back(exp);
    @(posedge clk);
    e = sb_q.pop_front();
    chk(tag, {7'd0, obs}, {7'd0, e});
    chk({tag, "_cnt"}, {12'd0, stall_count}, 16'(exp_stall));
    chk({tag, "_to"}, {15'd0, mem_timeout}, {15'd0, exp_to});
    if (stat_clear) exp_stall = 0;
    else if (!e[8] && exp_stall < 15) exp_stall++;
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
    dmem_req = 1'b0; dmem_ready = 1'b0; err_clear = 1'b0; stat_clear = 1'b0;
  endtask

  task automatic set_load_use();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    #2;
    chk("rst_ctl", {7'd0, obs}, {7'd0, NORM0});
    chk("rst_cnt", {12'd0, stall_count}, 16'd0);
    chk("rst_to", {15'd0, mem_timeout}, 16'd0);
    @(posedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;

    step("normal", NORM0);
    set_load_use();
    step("lu_rs2", LU0);
    idle_inputs();
    step("lu_after", NORM0);
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0; id_uses_rs2 = 1'b1;
    step("lu_x0", NORM0);
    ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs2 = 1'b0; id_uses_rs1 = 1'b0;
    step("lu_unused", NORM0);
    id_uses_rs1 = 1'b1;
    step("lu_rs1", LU0);

    idle_inputs();
    set_load_use();
    ex_branch_taken = 1'b1;
    step("br_lu", BR0);
    ex_branch_taken = 1'b0;
    step("fl_lu_ign", FL1);
    idle_inputs();
    step("fl_last", FL1);
    step("fl_done", NORM0);

    ex_branch_taken = 1'b1;
    step("br2", BR0);
    ex_branch_taken = 1'b0;
    step("fl2_a", FL1);
    ex_branch_taken = 1'b1;
    step("fl_rebr", FLBR1);
    ex_branch_taken = 1'b0;
    step("fl2_b", FL1);
    stat_clear = 1'b1;
    step("fl2_c", FL1);
    stat_clear = 1'b0;
    step("fl2_done", NORM0);

    dmem_req = 1'b1;
    step("mw_enter", HOLD0);
    for (int i = 0; i < 3; i++) step("mw_hold", HOLD2);
    dmem_ready = 1'b1;
    step("mw_ready", NORM2);
    idle_inputs();
    step("mw_after", NORM0);

    ex_branch_taken = 1'b1;
    step("br3", BR0);
    ex_branch_taken = 1'b0;
    dmem_req = 1'b1;
    step("fl_hold", HOLD1);
    step("fl_mw", HOLD2);
    dmem_req = 1'b0;
    step("fl_mw_drop", NORM2);
    step("fl_resume", FL1);
    step("fl_resume2", FL1);
    step("fl_resume_done", NORM0);

    dmem_req = 1'b1;
    step("to_enter", HOLD0);
    for (int i = 0; i < 7; i++) step("to_hold", HOLD2);
    err_clear = 1'b1;
    step("to_fire", NORM2);
    exp_to = 1'b1;
    idle_inputs();
    step("to_sticky", NORM0);

    set_load_use();
    stat_clear = 1'b1;
    step("stat_clr", LU0);
    stat_clear = 1'b0;
    for (int i = 0; i < 20; i++) step("sat_lu", LU0);
    idle_inputs();
    err_clear = 1'b1;
    step("sat_hold", NORM0);
    exp_to = 1'b0;
    err_clear = 1'b0;
    step("err_cleared", NORM0);

    dmem_req = 1'b1;
    step("to2_enter", HOLD0);
    for (int i = 0; i < 7; i++) step("to2_hold", HOLD2);
    step("to2_fire", NORM2);
    exp_to = 1'b1;
    step("rehold", HOLD0);
    step("rehold_mw", HOLD2);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_ctl", {7'd0, obs}, {7'd0, NORM0});
    chk("midrst_cnt", {12'd0, stall_count}, 16'd0);
    chk("midrst_to", {15'd0, mem_timeout}, 16'd0);
    @(posedge clk);
    reset = 1'b1;
    idle_inputs();
    exp_stall = 0;
    exp_to = 1'b0;
    @(negedge clk);
    #1;
    step("post_rst", NORM0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
